// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch squashes and
// multi-cycle data-memory waits, plus a stall-cycle counter and timeout flag.
module hazard_control_unit #(
    parameter int CNT_W        = 16,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_uses_rs1,
    input  logic             IFID_uses_rs2,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_mem_read,
    input  logic             EXMEM_mem_read,
    input  logic             EXMEM_mem_write,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_bubble,
    output logic             EXMEM_hold,
    output logic             MEMWB_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              mem_pend;
    logic              load_use;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
    endfunction

    assign mem_pend = (EXMEM_mem_read | EXMEM_mem_write) & ~mem_ready;
    assign load_use = IDEX_mem_read & (IDEX_rd != 5'd0) &
                      (((IDEX_rd == IFID_rs1) & IFID_uses_rs1) |
                       ((IDEX_rd == IFID_rs2) & IFID_uses_rs2));
    assign wait_nxt = sat_inc_wait(wait_cnt);

    // Memory wait outranks everything: a taken branch stays in EX until release.
    always_comb begin
        pc_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_write   = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_hold   = 1'b0;
        MEMWB_bubble = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (mem_pend) begin
            pc_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_hold   = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN:      if (mem_pend)  state <= MEM_WAIT;
                MEM_WAIT: if (mem_ready) state <= RUN;
                default:                 state <= RUN;
            endcase
            if (mem_pend) begin
                wait_cnt <= wait_nxt;
                if ((wait_cnt != WAIT_MAX) && (wait_nxt == WAIT_MAX))
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (!pc_write)
                stall_count <= sat_inc_cnt(stall_count);
        end
    end

endmodule
